ship_action_controller: RTL and testbench
=========================================

Name: ship_action_controller

Overview:
- Frame-synchronous game controller for the Nexys starship display. Converts button presses into shield activations, with a hold timer and a cooldown, and into cannon shots whose positions advance once per frame.
- Registered outputs drive the renderer's shield enables and shot sprites.
- All state changes occur at a single per-frame tick during vertical blanking, so the renderer never sees a mid-frame change.

Parameters:
- TICK_LINE, 516: vCount value, together with hCount==0, that generates frame_tick. It is the first line after the active area.
- SHIELD_FRAMES, 90: frames a shield stays raised. Range 1..255.
- COOLDOWN_FRAMES, 60: frames after a shield drops during which no shield may be raised. Range 1..255.
- SHOT_SPEED, 4: pixels a shot moves per frame. Range 1..15.
- UP_START_Y, 187: launch vCount of the top-cannon shot.
- DN_START_Y, 365: launch vCount of the bottom-cannon shot.
- SHOT_TOP_Y, 35: topmost visible vCount.
- SHOT_BOT_Y, 515: bottom-most visible vCount.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- up  in  1  fire top cannon (level, already synchronised)
- down  in  1  fire bottom cannon
- left  in  1  raise left shield
- right  in  1  raise right shield
- hCount  in  10  horizontal pixel counter
- vCount  in  10  vertical line counter
- frame_tick  out  1  one-cycle pulse per frame
- shield_l_on  out  1  left shield visible
- shield_r_on  out  1  right shield visible
- shield_cool  out  1  cooldown in progress
- shot_up_active  out  1  top shot in flight
- shot_up_y  out  10  top shot vCount
- shot_dn_active  out  1  bottom shot in flight
- shot_dn_y  out  10  bottom shot vCount

Behaviour:
- Reset (asynchronous on rst_n low): all outputs 0, FSM in S_IDLE, timers 0, pending flags 0, button history 0.
- frame_tick: registered; high for exactly one clk on the cycle after hCount==0 && vCount==TICK_LINE is seen.
- Press capture:
  - Each button is rising-edge detected against a one-cycle history register.
  - An edge sets a sticky pending flag.
  - All pending flags clear on the frame_tick cycle, whether or not the press was consumed.
  - A press that arrives in the same cycle as frame_tick is still consumed by that tick.
- Update timing: state and outputs update only on frame_tick cycles, so outputs are valid from tick+1.
- Latency from a press to output change: up to one frame plus two clk cycles.
- Shield FSM transitions (on tick only):
  - S_IDLE: pend_left → S_LEFT, timer=SHIELD_FRAMES-1. Else pend_right → S_RIGHT, timer=SHIELD_FRAMES-1. Left wins when both are pending.
  - S_LEFT / S_RIGHT: timer==0 → S_COOL, timer=COOLDOWN_FRAMES-1; else timer-1. Presses are discarded.
  - S_COOL: timer==0 → S_IDLE; else timer-1. Presses are discarded.
- Shield outputs: shield_l_on = (state==S_LEFT), shield_r_on = (state==S_RIGHT), shield_cool = (state==S_COOL). All registered.
- Shot channel (identical logic for up and down, differing only in direction):
  - Idle and pending: active=1, y=START_Y.
  - Active, up channel: if y < SHOT_TOP_Y+SHOT_SPEED then active=0, else y=y-SHOT_SPEED.
  - Active, down channel: if y+SHOT_SPEED > SHOT_BOT_Y then active=0, else y=y+SHOT_SPEED.
  - Active and a new press arrives: the press is ignored (only one shot per cannon in flight).
  - Retire cycle: y holds its last value. Retire and relaunch never occur on the same tick.
- Arithmetic: 10-bit unsigned. Compare before add or subtract so y never wraps. Bound checks use 11-bit sums.
- Independence: shields and shots are independent; simultaneous up+down+left on one tick launches both shots and raises the left shield.

Optional Feature:
- Macro: AUTOFIRE_EN.
- Defined: the up and down launch conditions use the button level sampled at the tick instead of the pending flag. A held button relaunches on the tick after the previous shot retires.
- Undefined: launch is edge-only and a held button fires once.

Decomposition:
- Package ship_pkg holds:
  - shield state enum (S_IDLE, S_LEFT, S_RIGHT, S_COOL, 2 bits);
  - screen origin constants H_ORIGIN=144 and V_ORIGIN=35;
  - cannon geometry constants feeding UP_START_Y and DN_START_Y.
- One sub-module, ship_shot_channel, parameterised by DIR (up/down), START_Y and LIMIT_Y, instantiated twice.

Test Plan (overrides SHIELD_FRAMES=3, COOLDOWN_FRAMES=2):
- Tick generation: hCount/vCount sweep through two frames → frame_tick pulses exactly once per frame, one cycle after (0,516); no pulses otherwise.
- Shield lifecycle: pulse left mid-frame → shield_l_on=1 after next tick and held for 3 ticks, then shield_cool=1 for 2 ticks, then both 0. A right press during cooldown → ignored.
- Simultaneous shields: left and right rise in the same cycle → only shield_l_on=1.
- Top shot: press up → after tick shot_up_y=187. Each tick −4 until y=35, which is less than 39 → next tick active=0, y stays 35. A second press while active → no relaunch.
- Bottom shot and reset: press down → y=365, 369, …, 513, then active=0 on the tick where 513+4>515. rst_n low mid-flight → all outputs 0 immediately, without waiting for a clk edge.
- AUTOFIRE_EN: hold up for 60 frames → shot relaunches at 187 on the tick after each retirement. Without the macro → a single launch.

Source files
------------

// File: rtl/ship_action_controller_pkg.sv
// Shared types and screen geometry for the starship action controller.
// Optional autofire is selected with the AUTOFIRE_EN macro (see top module).
package ship_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2,
        S_COOL  = 2'd3
    } shield_state_e;

    localparam int unsigned H_ORIGIN = 32'd144;
    localparam int unsigned V_ORIGIN = 32'd35;

    // Cannon muzzle offsets below the top of the visible area.
    localparam int unsigned UP_CANNON_OFS = 32'd152;
    localparam int unsigned DN_CANNON_OFS = 32'd330;

    localparam logic [9:0] UP_START_Y_DEF = 10'(V_ORIGIN + UP_CANNON_OFS);
    localparam logic [9:0] DN_START_Y_DEF = 10'(V_ORIGIN + DN_CANNON_OFS);
    localparam logic [9:0] SHOT_TOP_Y_DEF = 10'(V_ORIGIN);
    localparam logic [9:0] SHOT_BOT_Y_DEF = 10'd515;
    localparam logic [9:0] TICK_LINE_DEF  = 10'd516;

    localparam bit DIR_UP = 1'b0;
    localparam bit DIR_DN = 1'b1;

endpackage

// File: rtl/ship_action_controller_if.sv
// Button/raster inputs and renderer outputs of the action controller.
interface ship_action_if;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       frame_tick;
    logic       shield_l_on;
    logic       shield_r_on;
    logic       shield_cool;
    logic       shot_up_active;
    logic [9:0] shot_up_y;
    logic       shot_dn_active;
    logic [9:0] shot_dn_y;

    modport master (
        output up, down, left, right, hCount, vCount,
        input  frame_tick, shield_l_on, shield_r_on, shield_cool,
        input  shot_up_active, shot_up_y, shot_dn_active, shot_dn_y
    );

    modport slave (
        input  up, down, left, right, hCount, vCount,
        output frame_tick, shield_l_on, shield_r_on, shield_cool,
        output shot_up_active, shot_up_y, shot_dn_active, shot_dn_y
    );
endinterface

// File: rtl/ship_action_controller_shot_channel.sv
// One cannon shot: launches at START_Y and moves SPEED lines per tick toward LIMIT_Y.
module ship_shot_channel
    import ship_pkg::*;
#(
    parameter bit         DIR     = DIR_UP,
    parameter logic [9:0] START_Y = UP_START_Y_DEF,
    parameter logic [9:0] LIMIT_Y = SHOT_TOP_Y_DEF,
    parameter logic [3:0] SPEED   = 4'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_launch,
    output logic       o_active,
    output logic [9:0] o_y
);

    logic       r_active;
    logic [9:0] r_y;
    logic [10:0] w_bound;
    logic        w_retire;
    logic [9:0]  w_y_step;

    // Bound test happens before the step so y can never wrap.
    always_comb begin
        w_bound  = 11'd0;
        w_retire = 1'b0;
        w_y_step = r_y;
        if (DIR == DIR_UP) begin
            w_bound  = {1'b0, LIMIT_Y} + {7'd0, SPEED};
            w_retire = ({1'b0, r_y} < w_bound);
            w_y_step = r_y - {6'd0, SPEED};
        end else begin
            w_bound  = {1'b0, r_y} + {7'd0, SPEED};
            w_retire = (w_bound > {1'b0, LIMIT_Y});
            w_y_step = r_y + {6'd0, SPEED};
        end
    end

    // Flight state; retire and relaunch are mutually exclusive on a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_y      <= 10'd0;
        end else if (i_tick) begin
            if (r_active) begin
                if (w_retire) begin
                    r_active <= 1'b0;
                end else begin
                    r_y <= w_y_step;
                end
            end else if (i_launch) begin
                r_active <= 1'b1;
                r_y      <= START_Y;
            end
        end
    end

    assign o_active = r_active;
    assign o_y      = r_y;

endmodule

// File: rtl/ship_action_controller.sv
// Frame-synchronous shield/cannon controller; all state moves on the vblank tick.
// Define AUTOFIRE_EN to launch shots from the held button level instead of edges.
module ship_action_controller
    import ship_pkg::*;
#(
    parameter logic [9:0]  TICK_LINE       = TICK_LINE_DEF,
    parameter int unsigned SHIELD_FRAMES   = 32'd90,
    parameter int unsigned COOLDOWN_FRAMES = 32'd60,
    parameter logic [3:0]  SHOT_SPEED      = 4'd4,
    parameter logic [9:0]  UP_START_Y      = UP_START_Y_DEF,
    parameter logic [9:0]  DN_START_Y      = DN_START_Y_DEF,
    parameter logic [9:0]  SHOT_TOP_Y      = SHOT_TOP_Y_DEF,
    parameter logic [9:0]  SHOT_BOT_Y      = SHOT_BOT_Y_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    ship_action_if.slave  bus
);

    localparam logic [7:0] SHIELD_LOAD = 8'(SHIELD_FRAMES - 32'd1);
    localparam logic [7:0] COOL_LOAD   = 8'(COOLDOWN_FRAMES - 32'd1);

    // Button vector order: {up, down, left, right}.
    logic [3:0]    w_btn;
    logic [3:0]    w_edge;
    logic [3:0]    w_take;
    logic [3:0]    r_hist;
    logic [3:0]    r_pend;
    logic          r_tick;
    shield_state_e r_state;
    shield_state_e w_state_nxt;
    logic [7:0]    r_timer;
    logic [7:0]    w_timer_nxt;
    logic          r_shield_l;
    logic          r_shield_r;
    logic          r_shield_c;
    logic          w_launch_up;
    logic          w_launch_dn;

    assign w_btn  = {bus.up, bus.down, bus.left, bus.right};
    assign w_edge = w_btn & ~r_hist;
    assign w_take = r_pend | w_edge;

    // Tick generation and sticky press capture; a tick clears every pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= 1'b0;
            r_hist <= 4'd0;
            r_pend <= 4'd0;
        end else begin
            r_tick <= (bus.hCount == 10'd0) && (bus.vCount == TICK_LINE);
            r_hist <= w_btn;
            r_pend <= r_tick ? 4'd0 : (r_pend | w_edge);
        end
    end

    // Shield next-state; presses outside S_IDLE are simply dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        case (r_state)
            S_IDLE: begin
                if (w_take[1]) begin
                    w_state_nxt = S_LEFT;
                    w_timer_nxt = SHIELD_LOAD;
                end else if (w_take[0]) begin
                    w_state_nxt = S_RIGHT;
                    w_timer_nxt = SHIELD_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LEFT, S_RIGHT: begin
                if (r_timer == 8'd0) begin
                    w_state_nxt = S_COOL;
                    w_timer_nxt = COOL_LOAD;
                end else begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end
            S_COOL: begin
                if (r_timer == 8'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = 8'd0;
            end
        endcase
    end

    // Shield state and its decoded outputs, committed only on the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= 8'd0;
            r_shield_l <= 1'b0;
            r_shield_r <= 1'b0;
            r_shield_c <= 1'b0;
        end else if (r_tick) begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_shield_l <= (w_state_nxt == S_LEFT);
            r_shield_r <= (w_state_nxt == S_RIGHT);
            r_shield_c <= (w_state_nxt == S_COOL);
        end
    end

`ifdef AUTOFIRE_EN
    assign w_launch_up = bus.up;
    assign w_launch_dn = bus.down;
`else
    assign w_launch_up = w_take[3];
    assign w_launch_dn = w_take[2];
`endif

    ship_shot_channel #(
        .DIR(DIR_UP), .START_Y(UP_START_Y), .LIMIT_Y(SHOT_TOP_Y), .SPEED(SHOT_SPEED)
    ) u_shot_up (
        .clk(clk), .rst_n(rst_n), .i_tick(r_tick), .i_launch(w_launch_up),
        .o_active(bus.shot_up_active), .o_y(bus.shot_up_y)
    );

    ship_shot_channel #(
        .DIR(DIR_DN), .START_Y(DN_START_Y), .LIMIT_Y(SHOT_BOT_Y), .SPEED(SHOT_SPEED)
    ) u_shot_dn (
        .clk(clk), .rst_n(rst_n), .i_tick(r_tick), .i_launch(w_launch_dn),
        .o_active(bus.shot_dn_active), .o_y(bus.shot_dn_y)
    );

    assign bus.frame_tick  = r_tick;
    assign bus.shield_l_on = r_shield_l;
    assign bus.shield_r_on = r_shield_r;
    assign bus.shield_cool = r_shield_c;

endmodule

// File: tb/tb_ship_action_controller.sv
// Randomised + directed bench for ship_action_controller against a frame-level model.
module tb_ship_action_controller;

    localparam int SF   = 3;
    localparam int CF   = 2;
    localparam int SPD  = 4;
    localparam int UPY  = 187;
    localparam int DNY  = 365;
    localparam int TOPY = 35;
    localparam int BOTY = 515;
    localparam int TL   = 516;
`ifdef AUTOFIRE_EN
    localparam int EXP_LAUNCHES = 2;
`else
    localparam int EXP_LAUNCHES = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ship_action_if bus();

    ship_action_controller #(
        .SHIELD_FRAMES(SF),
        .COOLDOWN_FRAMES(CF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int n_vec = 0;
    int n_miss = 0;
    int tick_seen = 0;

    // Model: shield mode 0 idle, 1 left, 2 right, 3 cooldown; m_rem = ticks left in mode.
    bit       m_tick;
    bit [3:0] m_hist;
    bit [3:0] m_pend;
    int       m_mode;
    int       m_rem;
    bit       m_ua;
    int       m_uy;
    bit       m_da;
    int       m_dy;

    always @(negedge clk) if (bus.frame_tick === 1'b1) tick_seen++;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tick = 1'b0; m_hist = 4'd0; m_pend = 4'd0;
        m_mode = 0; m_rem = 0;
        m_ua = 1'b0; m_uy = 0; m_da = 1'b0; m_dy = 0;
    endtask

    task automatic model_step(input bit [3:0] btn, input int h, input int v);
        bit [3:0] e;
        bit [3:0] p;
        bit lu;
        bit ld;
        e = btn & ~m_hist;
        if (m_tick) begin
            p = m_pend | e;
            case (m_mode)
                0: begin
                    if (p[1]) begin m_mode = 1; m_rem = SF; end
                    else if (p[0]) begin m_mode = 2; m_rem = SF; end
                end
                1, 2: begin
                    m_rem--;
                    if (m_rem == 0) begin m_mode = 3; m_rem = CF; end
                end
                default: begin
                    m_rem--;
                    if (m_rem == 0) m_mode = 0;
                end
            endcase
`ifdef AUTOFIRE_EN
            lu = btn[3]; ld = btn[2];
`else
            lu = p[3]; ld = p[2];
`endif
            if (m_ua) begin
                if (m_uy - SPD < TOPY) m_ua = 1'b0; else m_uy -= SPD;
            end else if (lu) begin
                m_ua = 1'b1; m_uy = UPY;
            end
            if (m_da) begin
                if (m_dy + SPD > BOTY) m_da = 1'b0; else m_dy += SPD;
            end else if (ld) begin
                m_da = 1'b1; m_dy = DNY;
            end
            m_pend = 4'd0;
        end else begin
            m_pend |= e;
        end
        m_hist = btn;
        m_tick = (h == 0) && (v == TL);
    endtask

    task automatic check_all();
        check("frame_tick", 16'(bus.frame_tick), 16'(m_tick));
        check("shield_l_on", 16'(bus.shield_l_on), 16'(m_mode == 1));
        check("shield_r_on", 16'(bus.shield_r_on), 16'(m_mode == 2));
        check("shield_cool", 16'(bus.shield_cool), 16'(m_mode == 3));
        check("shot_up_active", 16'(bus.shot_up_active), 16'(m_ua));
        check("shot_up_y", 16'(bus.shot_up_y), 16'(m_uy));
        check("shot_dn_active", 16'(bus.shot_dn_active), 16'(m_da));
        check("shot_dn_y", 16'(bus.shot_dn_y), 16'(m_dy));
    endtask

    task automatic cyc(input bit [3:0] btn, input int h, input int v);
        @(negedge clk);
        check_all();
        {bus.up, bus.down, bus.left, bus.right} = btn;
        bus.hCount = 10'(h);
        bus.vCount = 10'(v);
        model_step(btn, h, v);
    endtask

    // One short frame; returns #1 after the tick-consuming edge so outputs are fresh.
    task automatic frame(input bit [3:0] press, input bit [3:0] hold);
        cyc(press | hold, 100, 200);
        cyc(hold, 101, 200);
        cyc(hold, 0, TL);
        cyc(hold, 5, TL);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit [3:0] rbtn;
        int launches;
        bit prev_act;

        {bus.up, bus.down, bus.left, bus.right} = 4'd0;
        bus.hCount = 10'd0;
        bus.vCount = 10'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Tick generation over the rows around the tick line, twice.
        tick_seen = 0;
        for (int rep = 0; rep < 2; rep++)
            for (int v = 514; v < 518; v++)
                for (int h = 0; h < 800; h++)
                    cyc(4'd0, h, v);
        cyc(4'd0, 1, 1);
        check("tick_count", 16'(tick_seen), 16'd2);

        // Shield lifecycle with a right press during cooldown.
        frame(4'b0010, 4'd0); check("lc_l1", 16'(bus.shield_l_on), 16'd1);
        frame(4'd0, 4'd0);    check("lc_l2", 16'(bus.shield_l_on), 16'd1);
        frame(4'd0, 4'd0);    check("lc_l3", 16'(bus.shield_l_on), 16'd1);
        frame(4'd0, 4'd0);    check("lc_c1", 16'(bus.shield_cool), 16'd1);
        frame(4'b0001, 4'd0); check("lc_c2", 16'(bus.shield_cool), 16'd1);
        frame(4'd0, 4'd0);
        check("lc_end", 16'({bus.shield_l_on, bus.shield_r_on, bus.shield_cool}), 16'd0);
        frame(4'd0, 4'd0);    check("lc_r_ign", 16'(bus.shield_r_on), 16'd0);

        // Simultaneous left and right: left wins.
        frame(4'b0011, 4'd0);
        check("sim_l", 16'(bus.shield_l_on), 16'd1);
        check("sim_r", 16'(bus.shield_r_on), 16'd0);
        repeat (6) frame(4'd0, 4'd0);

        // Top shot full flight, second press while active ignored.
        frame(4'b1000, 4'd0);
        check("up_launch_y", 16'(bus.shot_up_y), 16'd187);
        for (int k = 0; k < 38; k++) frame((k == 5) ? 4'b1000 : 4'd0, 4'd0);
        check("up_last_y", 16'(bus.shot_up_y), 16'd35);
        check("up_last_act", 16'(bus.shot_up_active), 16'd1);
        frame(4'd0, 4'd0);
        check("up_retire_act", 16'(bus.shot_up_active), 16'd0);
        check("up_retire_y", 16'(bus.shot_up_y), 16'd35);

        // Bottom shot full flight, then async reset mid-flight.
        frame(4'b0100, 4'd0);
        check("dn_launch_y", 16'(bus.shot_dn_y), 16'd365);
        for (int k = 0; k < 37; k++) frame(4'd0, 4'd0);
        check("dn_last_y", 16'(bus.shot_dn_y), 16'd513);
        frame(4'd0, 4'd0);
        check("dn_retire_act", 16'(bus.shot_dn_active), 16'd0);
        check("dn_retire_y", 16'(bus.shot_dn_y), 16'd513);
        frame(4'b1110, 4'd0);
        check("indep_all", 16'({bus.shot_up_active, bus.shot_dn_active, bus.shield_l_on}), 16'd7);
        frame(4'd0, 4'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", 16'({bus.frame_tick, bus.shield_l_on, bus.shield_r_on,
              bus.shield_cool, bus.shot_up_active, bus.shot_dn_active}), 16'd0);
        check("async_rst_upy", 16'(bus.shot_up_y), 16'd0);
        check("async_rst_dny", 16'(bus.shot_dn_y), 16'd0);
        {bus.up, bus.down, bus.left, bus.right} = 4'd0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Held up button for 60 frames.
        launches = 0;
        prev_act = 1'b0;
        for (int f = 0; f < 60; f++) begin
            frame(4'd0, 4'b1000);
            if (bus.shot_up_active === 1'b1 && !prev_act) launches++;
            prev_act = (bus.shot_up_active === 1'b1);
        end
        check("autofire_launches", 16'(launches), 16'(EXP_LAUNCHES));

        // Random buttons and raster positions with frequent ticks.
        rbtn = 4'd0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) rbtn[b] = ~rbtn[b];
            if ($urandom_range(0, 4) == 0) cyc(rbtn, 0, TL);
            else cyc(rbtn, int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
        end
        cyc(4'd0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
